id_operand_stage: RTL and testbench

//  Parametrised decode-front for the 5-stage MIPS pipeline. It sits between IF and the ID decoder.
//  - Holds the IF->ID PC register.
//  - Preserves the synchronous-SRAM instruction word across stalls with a LIVE/HELD hold FSM.
//  - Resolves rs/rt operands through an N-source priority bypass network.
//  - Raises a load-use stall request for any configured load latency.
//  - Counts load-use stall cycles for performance monitoring.

---
 rtl/id_pkg.sv | 23 ++
 rtl/id_fwd_mux.sv | 49 ++++
 rtl/id_operand_stage.sv | 145 ++++++++++++++
 tb/tb_id_operand_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared definitions for the ID operand stage: default widths, the
// instruction-hold FSM state type, the bubble encoding and the rs/rt field
// positions inside a MIPS instruction word.
package id_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned AW_DEF   = 5;

    // LIVE: the decoder sees the SRAM output directly.
    // HELD: the decoder sees the word captured when a stall began.
    typedef enum logic {
        LIVE = 1'b0,
        HELD = 1'b1
    } hold_state_e;

    // All-zero word decodes as sll r0,r0,0, which is a nop.
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // Least-significant bit of the rs and rt register fields.
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_LSB = 16;

endpackage

// File: rtl/id_fwd_mux.sv
// Priority bypass for one operand.
// Ports:
//   addr        operand register address (r0 reads as zero, never forwards)
//   rf_rdata    register file read data, used when no source matches
//   fwd_we      per-source write enable
//   fwd_is_load per-source "data not final yet" flag
//   fwd_waddr   packed destination addresses, source k at [k*AW +: AW]
//   fwd_wdata   packed write data, source k at [k*XLEN +: XLEN]
//   value       resolved operand
//   load_hit    the winning source is a load that cannot forward yet
module id_fwd_mux
    import id_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned NFWD     = 3,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic [AW-1:0]        addr,
    input  logic [XLEN-1:0]      rf_rdata,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD-1:0]      fwd_is_load,
    input  logic [NFWD*AW-1:0]   fwd_waddr,
    input  logic [NFWD*XLEN-1:0] fwd_wdata,
    output logic [XLEN-1:0]      value,
    output logic                 load_hit
);

    logic found;

    // Lowest-index matching source wins; once found, older sources are ignored.
    always_comb begin
        value    = rf_rdata;
        load_hit = 1'b0;
        found    = 1'b0;
        if (addr == '0) begin
            value = '0;
        end else begin
            for (int k = 0; k < int'(NFWD); k++) begin
                if (!found && fwd_we[k] && (fwd_waddr[k*AW +: AW] == addr)) begin
                    found    = 1'b1;
                    value    = fwd_wdata[k*XLEN +: XLEN];
                    load_hit = fwd_is_load[k] && (k < int'(LOAD_LAT));
                end
            end
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode front for the 5-stage pipeline: IF->ID PC register, instruction
// hold across stalls for a synchronous instruction SRAM, rs/rt bypass,
// load-use stall request and a saturating stall-cycle counter.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ctrl_stall_if, ctrl_stall_id  controller stalls for IF and ID
//   flush                         squash ID contents
//   if_valid, if_pc               fetch PC and its valid
//   sram_rdata                    instruction SRAM data (one cycle after PC)
//   rf_raddr1/2, rf_rdata1/2      register file read ports
//   fwd_we/is_load/waddr/wdata    forwarding sources, index 0 youngest
//   use_rs, use_rt                decoder operand usage
//   id_valid, id_pc, id_inst      ID contents (id_inst is 0 when invalid)
//   rs_val, rt_val                resolved operands
//   stallreq                      load-use hazard request
//   stall_cnt                     saturating load-use stall cycle count
module id_operand_stage
    import id_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned NFWD     = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_stall_if,
    input  logic                 ctrl_stall_id,
    input  logic                 flush,
    input  logic                 if_valid,
    input  logic [PC_W-1:0]      if_pc,
    input  logic [XLEN-1:0]      sram_rdata,
    output logic [AW-1:0]        rf_raddr1,
    output logic [AW-1:0]        rf_raddr2,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [XLEN-1:0]      rf_rdata2,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD-1:0]      fwd_is_load,
    input  logic [NFWD*AW-1:0]   fwd_waddr,
    input  logic [NFWD*XLEN-1:0] fwd_wdata,
    input  logic                 use_rs,
    input  logic                 use_rt,
    output logic                 id_valid,
    output logic [PC_W-1:0]      id_pc,
    output logic [XLEN-1:0]      id_inst,
    output logic [XLEN-1:0]      rs_val,
    output logic [XLEN-1:0]      rt_val,
    output logic                 stallreq,
    output logic [CNT_W-1:0]     stall_cnt
);

    hold_state_e       state;
    logic [XLEN-1:0]   hold_r;
    logic [XLEN-1:0]   inst_raw;
    logic              rs_load_hit;
    logic              rt_load_hit;

    // IF->ID PC register; flush beats stall, an IF-only stall inserts a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (!ctrl_stall_id) begin
            if (ctrl_stall_if) begin
                id_valid <= 1'b0;
            end else begin
                id_valid <= if_valid;
                id_pc    <= if_pc;
            end
        end
    end

    // Hold FSM: capture the SRAM word on the first stalled cycle, because the
    // SRAM output moves on while ID is frozen. Flush drops the held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LIVE;
            hold_r <= '0;
        end else if (state == LIVE) begin
            if (ctrl_stall_id && id_valid && !flush) begin
                hold_r <= sram_rdata;
                state  <= HELD;
            end
        end else begin
            if (flush || !ctrl_stall_id) begin
                state <= LIVE;
            end
        end
    end

    // The release cycle is still HELD, so it presents the captured word.
    assign inst_raw  = (state == HELD) ? hold_r : sram_rdata;
    assign id_inst   = id_valid ? inst_raw : XLEN'(NOP_INST);

    assign rf_raddr1 = id_inst[RS_LSB +: AW];
    assign rf_raddr2 = id_inst[RT_LSB +: AW];

    id_fwd_mux #(
        .XLEN     (XLEN),
        .AW       (AW),
        .NFWD     (NFWD),
        .LOAD_LAT (LOAD_LAT)
    ) u_fwd_rs (
        .addr        (rf_raddr1),
        .rf_rdata    (rf_rdata1),
        .fwd_we      (fwd_we),
        .fwd_is_load (fwd_is_load),
        .fwd_waddr   (fwd_waddr),
        .fwd_wdata   (fwd_wdata),
        .value       (rs_val),
        .load_hit    (rs_load_hit)
    );

    id_fwd_mux #(
        .XLEN     (XLEN),
        .AW       (AW),
        .NFWD     (NFWD),
        .LOAD_LAT (LOAD_LAT)
    ) u_fwd_rt (
        .addr        (rf_raddr2),
        .rf_rdata    (rf_rdata2),
        .fwd_we      (fwd_we),
        .fwd_is_load (fwd_is_load),
        .fwd_waddr   (fwd_waddr),
        .fwd_wdata   (fwd_wdata),
        .value       (rt_val),
        .load_hit    (rt_load_hit)
    );

    assign stallreq = id_valid && ((use_rs && rs_load_hit) || (use_rt && rt_load_hit));

    // Saturating count of load-use stall cycles; flushed cycles are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stallreq && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage (CNT_W=2 so saturation is reachable).
module tb_id_operand_stage;

    logic        clk;
    logic        rst;
    logic        ctrl_stall_if;
    logic        ctrl_stall_id;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] sram_rdata;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [2:0]  fwd_we;
    logic [2:0]  fwd_is_load;
    logic [14:0] fwd_waddr;
    logic [95:0] fwd_wdata;
    logic        use_rs;
    logic        use_rt;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stallreq;
    logic [1:0]  stall_cnt;

    int total;
    int bad;
    int exp_cnt;

    id_operand_stage #(.CNT_W(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .ctrl_stall_if (ctrl_stall_if),
        .ctrl_stall_id (ctrl_stall_id),
        .flush         (flush),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .sram_rdata    (sram_rdata),
        .rf_raddr1     (rf_raddr1),
        .rf_raddr2     (rf_raddr2),
        .rf_rdata1     (rf_rdata1),
        .rf_rdata2     (rf_rdata2),
        .fwd_we        (fwd_we),
        .fwd_is_load   (fwd_is_load),
        .fwd_waddr     (fwd_waddr),
        .fwd_wdata     (fwd_wdata),
        .use_rs        (use_rs),
        .use_rt        (use_rt),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .rs_val        (rs_val),
        .rt_val        (rt_val),
        .stallreq      (stallreq),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", id_pc); end
        total++; if (id_inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", id_inst); end
        total++; if (stall_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_stall_hold();
        if_valid = 1'b1;
        if_pc    = 32'h100;
        tick();
        if_pc         = 32'h104;
        sram_rdata    = 32'h3C01_1234;
        ctrl_stall_id = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (id_inst !== 32'h3C01_1234) begin bad++; $display("FAIL stall_inst c%0d got=%h exp=3c011234", c, id_inst); end
            total++; if (id_pc !== 32'h100) begin bad++; $display("FAIL stall_pc c%0d got=%h exp=100", c, id_pc); end
            tick();
            sram_rdata = 32'hDEAD_BEEF;
        end
        // release cycle still shows the held word
        ctrl_stall_id = 1'b0;
        #1;
        total++; if (id_inst !== 32'h3C01_1234) begin bad++; $display("FAIL release_inst got=%h exp=3c011234", id_inst); end
        tick();
        sram_rdata = 32'h2002_0007;
        #1;
        total++; if (id_pc !== 32'h104) begin bad++; $display("FAIL next_pc got=%h exp=104", id_pc); end
        total++; if (id_inst !== 32'h2002_0007) begin bad++; $display("FAIL live_inst got=%h exp=20020007", id_inst); end
    endtask

    task automatic test_priority();
        if_pc = 32'h200;
        tick();
        sram_rdata  = 32'h00A0_0000;   // rs = 5
        use_rs      = 1'b1;
        rf_rdata1   = 32'h1111_1111;
        fwd_we      = 3'b111;
        fwd_is_load = 3'b000;
        fwd_waddr   = {5'd5, 5'd5, 5'd5};
        fwd_wdata   = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        #1;
        total++; if (rf_raddr1 !== 5'd5) begin bad++; $display("FAIL raddr1 got=%0d exp=5", rf_raddr1); end
        total++; if (rs_val !== 32'hAAAA_0001) begin bad++; $display("FAIL prio_src0 got=%h exp=aaaa0001", rs_val); end
        fwd_we = 3'b110;
        #1;
        total++; if (rs_val !== 32'hBBBB_0002) begin bad++; $display("FAIL prio_src1 got=%h exp=bbbb0002", rs_val); end
        fwd_we = 3'b000;
        #1;
        total++; if (rs_val !== 32'h1111_1111) begin bad++; $display("FAIL prio_rf got=%h exp=11111111", rs_val); end
        total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL prio_stall got=%b exp=0", stallreq); end
        use_rs = 1'b0;
    endtask

    task automatic test_load_use();
        sram_rdata  = 32'h0008_0000;   // rt = 8
        use_rt      = 1'b1;
        rf_rdata2   = 32'h2222_2222;
        fwd_we      = 3'b001;
        fwd_is_load = 3'b001;
        fwd_waddr   = {5'd0, 5'd0, 5'd8};
        fwd_wdata   = {32'h0, 32'h0, 32'h0000_0088};
        #1;
        total++; if (rf_raddr2 !== 5'd8) begin bad++; $display("FAIL raddr2 got=%0d exp=8", rf_raddr2); end
        total++; if (stallreq !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stallreq); end
        ctrl_stall_id = 1'b1;
        tick();
        exp_cnt = exp_cnt + 1;
        total++; if (stall_cnt !== 2'(exp_cnt)) begin bad++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
        fwd_we      = 3'b010;
        fwd_is_load = 3'b010;
        fwd_waddr   = {5'd0, 5'd8, 5'd0};
        fwd_wdata   = {32'h0, 32'h0000_0099, 32'h0};
        #1;
        total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL lu_old_stall got=%b exp=0", stallreq); end
        total++; if (rt_val !== 32'h0000_0099) begin bad++; $display("FAIL lu_old_val got=%h exp=99", rt_val); end
        // younger non-load match shadows the older load
        fwd_we      = 3'b011;
        fwd_is_load = 3'b010;
        fwd_waddr   = {5'd0, 5'd8, 5'd8};
        fwd_wdata   = {32'h0, 32'h0000_0099, 32'h0000_0077};
        #1;
        total++; if (rt_val !== 32'h0000_0077) begin bad++; $display("FAIL shadow_val got=%h exp=77", rt_val); end
        total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL shadow_stall got=%b exp=0", stallreq); end
        ctrl_stall_id = 1'b0;
        tick();
        total++; if (stall_cnt !== 2'(exp_cnt)) begin bad++; $display("FAIL lu_cnt_hold got=%0d exp=%0d", stall_cnt, exp_cnt); end
    endtask

    task automatic test_r0();
        sram_rdata  = 32'h0000_0000;
        use_rs      = 1'b1;
        use_rt      = 1'b1;
        fwd_we      = 3'b001;
        fwd_is_load = 3'b001;
        fwd_waddr   = 15'd0;
        fwd_wdata   = {32'h0, 32'h0, 32'hFFFF_FFFF};
        rf_rdata1   = 32'h5555_5555;
        #1;
        total++; if (rs_val !== 32'h0) begin bad++; $display("FAIL r0_val got=%h exp=0", rs_val); end
        total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL r0_stall got=%b exp=0", stallreq); end
        use_rs = 1'b0;
        use_rt = 1'b0;
        fwd_we = 3'b000;
    endtask

    task automatic test_flush_held();
        if_pc = 32'h300;
        tick();
        sram_rdata    = 32'h3C01_5555;
        ctrl_stall_id = 1'b1;
        tick();
        sram_rdata = 32'hDEAD_BEEF;
        tick();
        #1;
        total++; if (id_inst !== 32'h3C01_5555) begin bad++; $display("FAIL fl_held got=%h exp=3c015555", id_inst); end
        flush = 1'b1;
        tick();
        flush         = 1'b0;
        ctrl_stall_id = 1'b0;
        if_pc         = 32'h304;
        #1;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%b exp=0", id_valid); end
        total++; if (id_inst !== 32'h0) begin bad++; $display("FAIL fl_inst got=%h exp=0", id_inst); end
        tick();
        sram_rdata = 32'h0BAD_F00D;
        #1;
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL fl_refetch_valid got=%b exp=1", id_valid); end
        total++; if (id_pc !== 32'h304) begin bad++; $display("FAIL fl_refetch_pc got=%h exp=304", id_pc); end
        total++; if (id_inst !== 32'h0BAD_F00D) begin bad++; $display("FAIL fl_fresh got=%h exp=0badf00d", id_inst); end
        // IF-only stall inserts a bubble
        ctrl_stall_if = 1'b1;
        tick();
        ctrl_stall_if = 1'b0;
        #1;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL bubble_valid got=%b exp=0", id_valid); end
        total++; if (id_inst !== 32'h0) begin bad++; $display("FAIL bubble_inst got=%h exp=0", id_inst); end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        if_valid = 1'b1;
        if_pc    = 32'h400;
        tick();
        sram_rdata    = 32'h0008_0000;
        use_rt        = 1'b1;
        fwd_we        = 3'b001;
        fwd_is_load   = 3'b001;
        fwd_waddr     = {5'd0, 5'd0, 5'd8};
        ctrl_stall_id = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (stallreq !== 1'b1) begin bad++; $display("FAIL sat_req c%0d got=%b exp=1", i, stallreq); end
            tick();
            exp_cnt = (i + 1 > 3) ? 3 : i + 1;
            total++; if (stall_cnt !== 2'(exp_cnt)) begin bad++; $display("FAIL sat_cnt c%0d got=%0d exp=%0d", i, stall_cnt, exp_cnt); end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ctrl_stall_id = 1'b0;
        #1;
        total++; if (stall_cnt !== 2'd0) begin bad++; $display("FAIL sat_rst_cnt got=%0d exp=0", stall_cnt); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL sat_rst_valid got=%b exp=0", id_valid); end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        exp_cnt       = 0;
        rst           = 1'b1;
        ctrl_stall_if = 1'b0;
        ctrl_stall_id = 1'b0;
        flush         = 1'b0;
        if_valid      = 1'b0;
        if_pc         = 32'h0;
        sram_rdata    = 32'h0;
        rf_rdata1     = 32'h0;
        rf_rdata2     = 32'h0;
        fwd_we        = 3'b000;
        fwd_is_load   = 3'b000;
        fwd_waddr     = 15'd0;
        fwd_wdata     = 96'd0;
        use_rs        = 1'b0;
        use_rt        = 1'b0;

        test_reset();
        test_stall_hold();
        test_priority();
        test_load_use();
        test_r0();
        test_flush_held();
        test_saturation();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
